// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI monarch.
package spi_pkg;

  typedef enum logic [1:0] {IDLE, FRONTP, XFER, BACKP} state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK timebase: free-running half-period counter that emits edge and porch strobes.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int DIV_W = 4
)(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_load,
  input  state_t i_state,
  output logic   o_lead_stb,
  output logic   o_trail_stb,
  output logic   o_porch_stb
);

  localparam int CW = DIV_W - 1;

  logic [CW-1:0] r_cnt;
  logic          r_phase;
  logic          w_tick;

  assign w_tick = (i_state != IDLE) && (r_cnt == {CW{1'b1}});

  // r_phase is 0 when the next SCLK edge is a leading one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (i_load) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (i_state != IDLE) begin
      r_cnt <= r_cnt + CW'(1);
      if (w_tick && (i_state != BACKP)) r_phase <= ~r_phase;
    end
  end

  assign o_lead_stb  = w_tick && !r_phase && ((i_state == FRONTP) || (i_state == XFER));
  assign o_trail_stb = w_tick &&  r_phase &&  (i_state == XFER);
  assign o_porch_stb = w_tick && (i_state == BACKP);

endmodule

// File: rtl/spi_mnrch_mc.sv
// Parametrised full-duplex MSB-first SPI monarch with per-transfer CPOL/CPHA.
module spi_mnrch_mc
  import spi_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int DIV_W  = 4,
  parameter  int NUM_SS = 2,
  localparam int SEL_W  = (clog2(NUM_SS) > 1) ? clog2(NUM_SS) : 1
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrt,
  input  logic [DATA_W-1:0] cmd,
  input  logic [SEL_W-1:0]  ss_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              MISO,
  output logic              SCLK,
  output logic              MOSI,
  output logic [NUM_SS-1:0] SS_n,
  output logic              done,
  output logic              busy,
  output logic [DATA_W-1:0] rd_data
);

  localparam int BCW = clog2(DATA_W) + 1;

  state_t            r_state;
  spi_mode_t         r_mode;
  logic [DATA_W-1:0] r_sreg;
  logic              r_smpl;
  logic [BCW-1:0]    r_bitcnt;
  logic [NUM_SS-1:0] r_ss_n;
  logic              r_sclk;
  logic              r_done;
  logic              r_busy;
  logic              r_fin;

  logic              w_load;
  logic              w_lead;
  logic              w_trail;
  logic              w_porch;
  logic [DATA_W-1:0] w_shift;

  // r_fin blocks a start in the very cycle done rises
  assign w_load  = (r_state == IDLE) && wrt && !r_fin;
  assign w_shift = {r_sreg[DATA_W-2:0], r_smpl};

  spi_sclk_gen #(.DIV_W(DIV_W)) u_sclk_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_state     (r_state),
    .o_lead_stb  (w_lead),
    .o_trail_stb (w_trail),
    .o_porch_stb (w_porch)
  );

  always_ff @(posedge clk) begin
    if ((w_lead && !r_mode.cpha) || (w_trail && r_mode.cpha)) r_smpl <= MISO;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_mode   <= '{cpol: 1'b1, cpha: 1'b0};
      r_sreg   <= '0;
      r_bitcnt <= '0;
      r_ss_n   <= '1;
      r_sclk   <= 1'b1;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_fin    <= 1'b0;
    end else begin
      r_fin <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_sreg      <= cmd;
            r_mode.cpol <= cpol;
            r_mode.cpha <= cpha;
            r_bitcnt    <= '0;
            r_sclk      <= cpol;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            for (int i = 0; i < NUM_SS; i++) r_ss_n[i] <= (ss_sel != SEL_W'(i));
            r_state     <= FRONTP;
          end
        end
        FRONTP: begin
          // Edge 1 is leading; in CPHA=1 it never shifts
          if (w_lead) begin
            r_sclk  <= ~r_sclk;
            r_state <= XFER;
          end
        end
        XFER: begin
          if (w_lead) begin
            r_sclk <= ~r_sclk;
            if (r_mode.cpha) begin
              r_sreg   <= w_shift;
              r_bitcnt <= r_bitcnt + BCW'(1);
            end
          end
          if (w_trail) begin
            r_sclk <= ~r_sclk;
            if (!r_mode.cpha) begin
              r_sreg   <= w_shift;
              r_bitcnt <= r_bitcnt + BCW'(1);
            end
            if (r_bitcnt == BCW'(DATA_W - 1)) r_state <= BACKP;
          end
        end
        BACKP: begin
          if (w_porch) begin
            if (r_mode.cpha) r_sreg <= w_shift;
            r_ss_n  <= '1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_fin   <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign SCLK    = r_sclk;
  assign MOSI    = r_sreg[DATA_W-1];
  assign SS_n    = r_ss_n;
  assign done    = r_done;
  assign busy    = r_busy;
  assign rd_data = r_sreg;

endmodule

// File: tb/tb_spi_mnrch_mc.sv
// Self-checking bench for spi_mnrch_mc: serf model plus scoreboard of expected rd_data.
module tb_spi_mnrch_mc;

  localparam int DW       = 16;
  localparam int H        = 8;
  localparam int DONE_CYC = 1 + (2 * DW + 1) * H;
  localparam int DW2      = 8;
  localparam int H2       = 2;
  localparam int DONE2    = 1 + (2 * DW2 + 1) * H2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wrt = 1'b0;
  logic [15:0]   cmd = '0;
  logic          ss_sel = 1'b0;
  logic          cpol = 1'b1;
  logic          cpha = 1'b0;
  logic          MISO;
  logic          SCLK;
  logic          MOSI;
  logic [1:0]    SS_n;
  logic          done;
  logic          busy;
  logic [15:0]   rd_data;

  logic          wrt2 = 1'b0;
  logic [7:0]    cmd2 = '0;
  logic          ss_sel2 = 1'b0;
  logic          cpol2 = 1'b0;
  logic          cpha2 = 1'b0;
  logic          MISO2;
  logic          SCLK2;
  logic          MOSI2;
  logic [0:0]    SS_n2;
  logic          done2;
  logic          busy2;
  logic [7:0]    rd_data2;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [15:0]   exp_q[$];
  logic [7:0]    exp2_q[$];

  logic          lb = 1'b0;
  logic          m_cpol = 1'b1;
  logic          m_cpha = 1'b0;
  logic [15:0]   s_resp = '0;
  logic [15:0]   s_tx = '0;
  logic [15:0]   s_rx = '0;
  logic          s_first = 1'b0;
  logic          prev_sclk = 1'b1;
  logic          prev_busy = 1'b0;
  int            rise_cnt = 0;

  spi_mnrch_mc dut (
    .clk(clk), .rst_n(rst_n), .wrt(wrt), .cmd(cmd), .ss_sel(ss_sel),
    .cpol(cpol), .cpha(cpha), .MISO(MISO), .SCLK(SCLK), .MOSI(MOSI),
    .SS_n(SS_n), .done(done), .busy(busy), .rd_data(rd_data)
  );

  spi_mnrch_mc #(.DATA_W(8), .DIV_W(2), .NUM_SS(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .wrt(wrt2), .cmd(cmd2), .ss_sel(ss_sel2),
    .cpol(cpol2), .cpha(cpha2), .MISO(MISO2), .SCLK(SCLK2), .MOSI(MOSI2),
    .SS_n(SS_n2), .done(done2), .busy(busy2), .rd_data(rd_data2)
  );

  always #5 clk = ~clk;

  assign MISO  = lb ? MOSI : s_tx[15];
  assign MISO2 = MOSI2;

  // Serf model: samples and shifts on SCLK edges seen during busy
  always @(posedge clk) begin
    #2;
    if (busy && !prev_busy) begin
      s_tx     <= s_resp;
      s_rx     <= '0;
      s_first  <= 1'b1;
      rise_cnt <= 0;
    end else if (busy && (SCLK !== prev_sclk)) begin
      if (SCLK) rise_cnt <= rise_cnt + 1;
      if (SCLK != m_cpol) begin
        if (!m_cpha)     s_rx <= {s_rx[14:0], MOSI};
        else if (s_first) s_first <= 1'b0;
        else             s_tx <= {s_tx[14:0], 1'b0};
      end else begin
        if (!m_cpha) s_tx <= {s_tx[14:0], 1'b0};
        else         s_rx <= {s_rx[14:0], MOSI};
      end
    end
    prev_sclk <= SCLK;
    prev_busy <= busy;
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start(input logic [15:0] c, input logic sel, input logic pol,
                       input logic pha, input logic [15:0] resp, input logic loop,
                       output int t0);
    cmd    = c;
    ss_sel = sel;
    cpol   = pol;
    cpha   = pha;
    s_resp = resp;
    m_cpol = pol;
    m_cpha = pha;
    lb     = loop;
    wrt    = 1'b1;
    exp_q.push_back(loop ? c : resp);
    t0 = cyc;
    step();
    wrt = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int d);
    int seen;
    seen = 0;
    d = -1;
    for (int i = 0; i < budget && seen == 0; i++) begin
      if (done === 1'b1) begin
        seen = 1;
        d = cyc;
      end else begin
        step();
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++; if (SS_n !== 2'b11) begin errors++; $display("FAIL reset_ss_n got %b exp 11", SS_n); end
    checks++; if (SCLK !== 1'b1) begin errors++; $display("FAIL reset_sclk got %b exp 1", SCLK); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd got %h exp 0000", rd_data); end
    checks++; if (done2 !== 1'b0 || SS_n2 !== 1'b1) begin errors++; $display("FAIL reset_dut2 got done=%b ss=%b exp 0 1", done2, SS_n2); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_mode3_loopback();
    int t0, d;
    logic [15:0] e;
    start(16'hA5C3, 1'b0, 1'b1, 1'b1, 16'h0, 1'b1, t0);
    checks++; if (SS_n !== 2'b10) begin errors++; $display("FAIL m3_ss_n got %b exp 10", SS_n); end
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL m3_cycle1 got busy=%b done=%b exp 1 0", busy, done); end
    wait_done(DONE_CYC + 20, d);
    checks++; if (d - t0 != DONE_CYC) begin errors++; $display("FAIL m3_done_cycle got %0d exp %0d", d - t0, DONE_CYC); end
    e = exp_q.pop_front();
    checks++; if (rd_data !== e) begin errors++; $display("FAIL m3_rd got %h exp %h", rd_data, e); end
    checks++; if (SCLK !== 1'b1) begin errors++; $display("FAIL m3_sclk_idle got %b exp 1", SCLK); end
    checks++; if (rise_cnt != 16) begin errors++; $display("FAIL m3_rises got %0d exp 16", rise_cnt); end
    checks++; if (SS_n !== 2'b11 || busy !== 1'b0) begin errors++; $display("FAIL m3_end got ss=%b busy=%b exp 11 0", SS_n, busy); end
    step();
  endtask

  task automatic test_mode0();
    int t0, d;
    logic [15:0] e;
    start(16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, t0);
    checks++; if (SCLK !== 1'b0) begin errors++; $display("FAIL m0_sclk_c1 got %b exp 0", SCLK); end
    wait_done(DONE_CYC + 20, d);
    checks++; if (d - t0 != DONE_CYC) begin errors++; $display("FAIL m0_done_cycle got %0d exp %0d", d - t0, DONE_CYC); end
    e = exp_q.pop_front();
    checks++; if (rd_data !== e) begin errors++; $display("FAIL m0_rd got %h exp %h", rd_data, e); end
    checks++; if (s_rx !== 16'hBEEF) begin errors++; $display("FAIL m0_serf_rx got %h exp beef", s_rx); end
    checks++; if (SCLK !== 1'b0) begin errors++; $display("FAIL m0_sclk_idle got %b exp 0", SCLK); end
    step();
  endtask

  task automatic test_mode12();
    int t0, d;
    logic [15:0] e;
    for (int m = 1; m <= 2; m++) begin
      start(16'h7E5A, 1'b1, (m == 2), (m == 1), 16'h8001, 1'b0, t0);
      checks++; if (SS_n !== 2'b01) begin errors++; $display("FAIL m%0d_ss_n got %b exp 01", m, SS_n); end
      wait_done(DONE_CYC + 20, d);
      checks++; if (d - t0 != DONE_CYC) begin errors++; $display("FAIL m%0d_done_cycle got %0d exp %0d", m, d - t0, DONE_CYC); end
      e = exp_q.pop_front();
      checks++; if (rd_data !== e) begin errors++; $display("FAIL m%0d_rd got %h exp %h", m, rd_data, e); end
      checks++; if (s_rx !== 16'h7E5A) begin errors++; $display("FAIL m%0d_serf_rx got %h exp 7e5a", m, s_rx); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1, d;
    logic [15:0] e;
    t1 = 0;
    start(16'h5AA5, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, t0);
    for (int c = 1; c <= 267; c++) begin
      if (c == 50) begin
        cmd = 16'hFFFF; cpol = 1'b1; cpha = 1'b1; ss_sel = 1'b1; wrt = 1'b1;
      end
      if (c == 51) wrt = 1'b0;
      if (c == 100) begin
        checks++; if (SS_n !== 2'b10) begin errors++; $display("FAIL b2b_ss_mid got %b exp 10", SS_n); end
      end
      if (c == 264) begin
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_early_done got %b exp 0", done); end
      end
      if (c == 265) begin
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b exp 1", done); end
        e = exp_q.pop_front();
        checks++; if (rd_data !== e) begin errors++; $display("FAIL b2b_rd1 got %h exp %h", rd_data, e); end
        checks++; if (SCLK !== 1'b0) begin errors++; $display("FAIL b2b_sclk got %b exp 0", SCLK); end
        cmd = 16'hFFFF; wrt = 1'b1;
      end
      if (c == 266) begin
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_ignore_at_done got done=%b busy=%b exp 1 0", done, busy); end
        cmd = 16'h0F0F; cpol = 1'b0; cpha = 1'b0; ss_sel = 1'b0; wrt = 1'b1;
        exp_q.push_back(16'h0F0F);
        t1 = cyc;
      end
      if (c == 267) begin
        wrt = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_restart got done=%b busy=%b exp 0 1", done, busy); end
      end
      if (c < 267) step();
    end
    wait_done(DONE_CYC + 20, d);
    checks++; if (d - t1 != DONE_CYC) begin errors++; $display("FAIL b2b_done2_cycle got %0d exp %0d", d - t1, DONE_CYC); end
    e = exp_q.pop_front();
    checks++; if (rd_data !== e) begin errors++; $display("FAIL b2b_rd2 got %h exp %h", rd_data, e); end
    step();
  endtask

  task automatic test_reset_mid();
    int t0, d;
    logic [15:0] e;
    start(16'hC3A5, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, t0);
    while (cyc - t0 < 100) step();
    rst_n = 1'b0;
    #1;
    checks++; if (SS_n !== 2'b11 || SCLK !== 1'b1) begin errors++; $display("FAIL rmid_pins got ss=%b sclk=%b exp 11 1", SS_n, SCLK); end
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_flags got done=%b busy=%b exp 0 0", done, busy); end
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
    start(16'h3C96, 1'b1, 1'b1, 1'b1, 16'h0, 1'b1, t0);
    checks++; if (SS_n !== 2'b01) begin errors++; $display("FAIL rmid_ss_n got %b exp 01", SS_n); end
    wait_done(DONE_CYC + 20, d);
    checks++; if (d - t0 != DONE_CYC) begin errors++; $display("FAIL rmid_done_cycle got %0d exp %0d", d - t0, DONE_CYC); end
    e = exp_q.pop_front();
    checks++; if (rd_data !== e) begin errors++; $display("FAIL rmid_rd got %h exp %h", rd_data, e); end
    step();
  endtask

  task automatic test_small();
    int t0, d;
    logic [7:0] e;
    cmd2 = 8'h3C; cpol2 = 1'b0; cpha2 = 1'b1; ss_sel2 = 1'b0; wrt2 = 1'b1;
    exp2_q.push_back(8'h3C);
    t0 = cyc;
    step();
    wrt2 = 1'b0;
    checks++; if (SS_n2 !== 1'b0 || busy2 !== 1'b1) begin errors++; $display("FAIL small_c1 got ss=%b busy=%b exp 0 1", SS_n2, busy2); end
    d = -1;
    for (int i = 0; i < DONE2 + 20 && d < 0; i++) begin
      if (done2 === 1'b1) d = cyc;
      else step();
    end
    checks++; if (d - t0 != DONE2) begin errors++; $display("FAIL small_done_cycle got %0d exp %0d", d - t0, DONE2); end
    e = exp2_q.pop_front();
    checks++; if (rd_data2 !== e) begin errors++; $display("FAIL small_rd got %h exp %h", rd_data2, e); end
    checks++; if (SCLK2 !== 1'b0 || SS_n2 !== 1'b1) begin errors++; $display("FAIL small_idle got sclk=%b ss=%b exp 0 1", SCLK2, SS_n2); end
    step();
  endtask

  initial begin
    test_reset();
    test_mode3_loopback();
    test_mode0();
    test_mode12();
    test_back_to_back();
    test_reset_mid();
    test_small();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_mnrch_mc.md
Name: spi_mnrch_mc

Overview:
Parametrised SPI monarch (master) that replaces the fixed 16-bit, fixed-mode serial engine.
- Configurable word width, SCLK divider and number of slave selects.
- Per-transfer CPOL/CPHA mode, latched at wrt.
- Full-duplex, MSB-first; serves the segway inertial sensor, A2D and any future SPI serfs from one instance.

Parameters:
DATA_W, 16, transfer word width in bits (>=2)
DIV_W, 4, SCLK period = 2^DIV_W clk cycles; half-period H = 2^(DIV_W-1) (DIV_W>=2)
NUM_SS, 2, number of slave-select outputs (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
wrt  input  1  start-transfer strobe; sampled only when idle
cmd  input  DATA_W  word to transmit, latched at wrt
ss_sel  input  SEL_W=max(1,clog2(NUM_SS))  target serf index, latched at wrt
cpol  input  1  SCLK idle level, latched at wrt
cpha  input  1  0: sample leading edge; 1: sample trailing edge; latched at wrt
MISO  input  1  serial data from serf
SCLK  output  1  serial clock
MOSI  output  1  serial data to serf, = shift register MSB
SS_n  output  NUM_SS  active-low selects, one-hot-low during transfer
done  output  1  sticky transfer-complete flag
busy  output  1  high from cycle after accepted wrt until done rises
rd_data  output  DATA_W  received word, valid while done=1

Behaviour:
Clock and reset:
- Clock clk; reset rst_n, asynchronous, active-low.
- Reset values: SS_n all 1, SCLK 1 (cpol_q resets to 1), done 0, busy 0, rd_data 0, state IDLE.
- Reset mid-transfer aborts immediately, with no partial done.

State machine (IDLE, FRONTP, XFER, BACKP):
- IDLE:
  - SCLK = cpol_q.
  - wrt=1 loads shift reg <= cmd and latches ss_sel, cpol, cpha.
  - Next cycle (cycle 1): SS_n[ss_sel]=0, busy=1, done=0, SCLK = new cpol; go FRONTP.
  - ss_sel >= NUM_SS: transfer still runs with all SS_n high.
- FRONTP: H cycles. First SCLK edge occurs at cycle 1+H; go XFER.
- XFER:
  - 2*DATA_W SCLK edges, spaced H cycles apart. Edge k (k=1..2*DATA_W): odd = leading, even = trailing.
  - CPHA=0: leading edge captures MISO into a sample flop; trailing edge shifts {sreg[DATA_W-2:0], smpl}. MOSI is valid from cycle 1.
  - CPHA=1: trailing edge captures MISO; leading edges 2..DATA_W shift (no shift on the first leading edge).
  - After the last edge, go BACKP.
- BACKP:
  - H cycles after the last edge, SCLK held at cpol_q.
  - Final cycle: for CPHA=1, perform the last shift; SS_n all high, done=1, busy=0; go IDLE.
  - done is therefore asserted at cycle 1+(2*DATA_W+1)*H. Defaults give cycle 265.

Handshakes and boundaries:
- wrt while busy is ignored; cmd, ss_sel and mode changes mid-transfer have no effect.
- wrt in the same cycle done rises is ignored.
- wrt on any later cycle starts a new transfer with zero gap.
- done stays 1 until the next accepted wrt. rd_data holds until the next accepted wrt reloads the shift register.
- SCLK has no glitches: it toggles only on edge strobes and changes to a new cpol only in cycle 1.
- Bit counter width clog2(DATA_W)+1. No wrap: the transfer terminates at exactly DATA_W shifts.

Decomposition:
- Package spi_pkg holds:
  - state_t enum {IDLE, FRONTP, XFER, BACKP}
  - spi_mode_t struct {cpol, cpha}
  - function clog2 helper for SEL_W
- Sub-module spi_sclk_gen #(DIV_W):
  - Counter with load; outputs lead_stb, trail_stb and porch_stb pulses.
  - The top level contains the FSM, shift register, sample flop, bit counter, and SS_n/done/busy flops.

Test Plan:
- Mode 3 loopback (MISO=MOSI), cmd=16'hA5C3, ss_sel=0 -> SS_n=2'b10 during transfer; rd_data=16'hA5C3; done at cycle 265; SCLK idle 1; 16 rising edges.
- Mode 0 serf model returns 16'h1234 while cmd=16'hBEEF -> serf receives 16'hBEEF; rd_data=16'h1234; SCLK idles 0; MISO sampled on rising edges.
- Mode 1 and mode 2 with ss_sel=1, serf returns 16'h8001 -> rd_data=16'h8001; SS_n=2'b01; MSB and LSB correct (final back-porch shift exercised).
- wrt pulsed at cycles 50 and 265 with cmd=16'hFFFF -> ignored; the original word completes. wrt at cycle 266 starts a new transfer; done drops at 267.
- rst_n low at cycle 100 mid-transfer -> SS_n=all 1, SCLK=1, done=0, busy=0 asynchronously. The next wrt completes normally.
- Instance DATA_W=8, DIV_W=2, NUM_SS=1, loopback 8'h3C -> rd_data=8'h3C; done at cycle 1+17*2=35.
